// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one aligned imem read per
// instruction, holds the returned word for decode under valid/ready, and
// applies PC redirects while discarding any fetch that became stale.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_pc, w_pc_nx;
    logic [31:0] r_pend, w_pend_nx;     // redirect target waiting for the in-flight fetch to drain
    logic        r_kill, w_kill_nx;     // in-flight fetch is stale; replace pc with r_pend when it returns
    logic [31:0] r_inst, w_inst_nx;
    logic [31:0] r_inst_pc, w_inst_pc_nx;
    logic        r_fault, w_fault_nx;
    logic        w_misal;
    logic        w_acc;

    // A misaligned pc never reaches imem; REQ turns it straight into a faulting slot.
    assign w_misal        = (r_pc[1:0] != 2'b00);
    assign imem_req_valid = (r_state == S_REQ) && !w_misal;
    assign imem_req_addr  = {r_pc[31:2], 2'b00};
    assign w_acc          = imem_req_valid && imem_req_ready;

    assign inst_valid = (r_state == S_HOLD);
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_fault = r_fault;

    // Next-state, pc and held-instruction logic.
    always_comb begin
        w_state_nx   = r_state;
        w_pc_nx      = r_pc;
        w_pend_nx    = r_pend;
        w_kill_nx    = r_kill;
        w_inst_nx    = r_inst;
        w_inst_pc_nx = r_inst_pc;
        w_fault_nx   = r_fault;
        case (r_state)
            S_BOOT: begin
                w_state_nx = S_REQ;
                if (redirect_valid) w_pc_nx = redirect_pc;
            end
            S_REQ: begin
                if (w_misal) begin
                    // Nothing is in flight, so a redirect simply replaces the pc.
                    if (redirect_valid) begin
                        w_pc_nx = redirect_pc;
                    end else begin
                        w_state_nx   = S_HOLD;
                        w_inst_nx    = 32'h0;
                        w_inst_pc_nx = r_pc;
                        w_fault_nx   = 1'b1;
                    end
                end else begin
                    // The live request is never withdrawn; remember the target
                    // and kill the response it produces.
                    if (redirect_valid) begin
                        w_pend_nx = redirect_pc;
                        w_kill_nx = 1'b1;
                    end
                    if (w_acc) w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_pend_nx = redirect_pc;
                    w_kill_nx = 1'b1;
                end
                if (imem_rsp_valid) begin
                    if (redirect_valid || r_kill) begin
                        w_pc_nx    = redirect_valid ? redirect_pc : r_pend;
                        w_kill_nx  = 1'b0;
                        w_state_nx = S_REQ;
                    end else begin
                        w_state_nx   = S_HOLD;
                        w_inst_nx    = imem_rsp_err ? 32'h0 : imem_rsp_data;
                        w_inst_pc_nx = r_pc;
                        w_fault_nx   = imem_rsp_err;
                    end
                end
            end
            S_HOLD: begin
                // Redirect beats a coincident IDU handshake.
                if (redirect_valid) begin
                    w_pc_nx    = redirect_pc;
                    w_state_nx = S_REQ;
                end else if (inst_ready) begin
                    w_pc_nx    = r_pc + 32'd4;
                    w_state_nx = S_REQ;
                end
            end
            default: w_state_nx = S_BOOT;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_BOOT;
            r_pc      <= RESET_PC;
            r_pend    <= 32'h0;
            r_kill    <= 1'b0;
            r_inst    <= 32'h0;
            r_inst_pc <= 32'h0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_pc      <= w_pc_nx;
            r_pend    <= w_pend_nx;
            r_kill    <= w_kill_nx;
            r_inst    <= w_inst_nx;
            r_inst_pc <= w_inst_pc_nx;
            r_fault   <= w_fault_nx;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: an imem responder with programmable readiness and
// latency, an IDU sink, and a transaction-level model of the instruction
// stream (next pc = +4 per consumed inst, replaced by any redirect).
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid, imem_rsp_err;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready, inst_fault;
    logic [31:0] inst, inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_fault(inst_fault),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Stimulus knobs
    int rdy_mode = 0;      // 0 always ready, 1 random, 2 never
    int irdy_mode = 0;     // same encoding for inst_ready
    int lat_min = 1, lat_max = 1;
    int redir_rate = 0;    // 0 = no random redirects, else 1-in-N
    int spur_n = 0;        // cycles of unsolicited imem responses
    bit force_rv = 0;
    logic [31:0] force_pc = 0;

    // Model / responder state
    logic [31:0] exp_pc;
    bit          outst;
    int          cnt;
    logic [31:0] out_addr;
    int          cyc;
    int          n_hs;
    bit          prev_stall, prev_hold, prev_fault;
    logic [31:0] prev_addr, prev_inst, prev_ipc;
    logic [31:0] acc_a[$], hs_pc[$];
    int          acc_c[$], hs_c[$];

    function automatic logic [31:0] data_of(logic [31:0] a);
        return (a ^ 32'hA5C3_0F1E) + {a[15:0], a[31:16]};
    endfunction

    function automatic bit err_of(logic [31:0] a);
        return a[5:2] == 4'hB;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        acc_a.delete(); acc_c.delete(); hs_pc.delete(); hs_c.delete();
    endtask

    task automatic model_reset();
        exp_pc = RESET_PC; outst = 0; cnt = 0; cyc = 0;
        prev_stall = 0; prev_hold = 0;
    endtask

    function automatic bit pick(int mode);
        return (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    endfunction

    // One clock: check outputs at the negedge, drive inputs, advance the model.
    task automatic cycle();
        bit          hs, ef;
        logic [31:0] t;
        if (prev_stall) begin
            chk("req_held_valid", imem_req_valid, 1);
            chk("req_held_addr", imem_req_addr, prev_addr);
        end
        if (prev_hold) begin
            chk("hold_valid", inst_valid, 1);
            chk("hold_inst", inst, prev_inst);
            chk("hold_pc", inst_pc, prev_ipc);
            chk("hold_fault", inst_fault, prev_fault);
        end
        if (imem_req_valid) begin
            chk("req_align", imem_req_addr & 32'h3, 0);
            chk("one_outstanding", outst, 0);
        end
        if (inst_valid) begin
            ef = (exp_pc[1:0] != 2'b00) || err_of(exp_pc);
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_fault", inst_fault, ef);
            chk("inst", inst, ef ? 32'h0 : data_of(exp_pc));
        end

        imem_req_ready = pick(rdy_mode);
        inst_ready     = pick(irdy_mode);
        imem_rsp_valid = 0; imem_rsp_data = 0; imem_rsp_err = 0;
        if (outst) begin
            cnt--;
            if (cnt == 0) begin
                imem_rsp_valid = 1;
                imem_rsp_data  = data_of(out_addr);
                imem_rsp_err   = err_of(out_addr);
                outst = 0;
            end
        end else if (spur_n > 0) begin
            imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF; imem_rsp_err = 0;
            spur_n--;
        end
        t = {16'h8000, 4'h0, 10'($urandom), 2'b00};
        if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 31) == 0) t = 32'hFFFF_FFF8;
        redirect_valid = force_rv || (redir_rate != 0 && $urandom_range(0, redir_rate - 1) == 0);
        redirect_pc    = force_rv ? force_pc : t;
        force_rv = 0;

        if (imem_req_valid && imem_req_ready) begin
            outst = 1; cnt = $urandom_range(lat_min, lat_max); out_addr = imem_req_addr;
            acc_a.push_back(imem_req_addr); acc_c.push_back(cyc);
        end
        hs = inst_valid && inst_ready && !redirect_valid;
        if (redirect_valid) exp_pc = redirect_pc;
        else if (hs) begin
            hs_pc.push_back(inst_pc); hs_c.push_back(cyc);
            exp_pc = exp_pc + 32'd4; n_hs++;
        end
        prev_stall = imem_req_valid && !imem_req_ready;
        prev_addr  = imem_req_addr;
        prev_hold  = inst_valid && !inst_ready && !redirect_valid;
        prev_inst = inst; prev_ipc = inst_pc; prev_fault = inst_fault;
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!inst_valid && n < 40) begin cycle(); n++; end
        chk("wait_valid_timeout", inst_valid, 1);
    endtask

    initial begin
        rst_n = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        imem_rsp_err = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
        n_hs = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_fault", inst_fault, 0);

        // 1) sequential fetch, 1-cycle imem, IDU always ready
        rst_n = 1; spur_n = 2; clr();
        repeat (10) cycle();
        chk("t1_addr0", acc_a[0], 32'h8000_0000);
        chk("t1_addr1", acc_a[1], 32'h8000_0004);
        chk("t1_addr2", acc_a[2], 32'h8000_0008);
        chk("t1_latency", hs_c[0] - acc_c[0], 2);
        chk("t1_rate", hs_c[1] - hs_c[0], 3);
        chk("t1_rate2", hs_c[2] - hs_c[1], 3);
        chk("t1_pc2", hs_pc[2], 32'h8000_0008);

        // 2) imem not ready: request held, nothing delivered
        rdy_mode = 2; clr();
        repeat (5) cycle();
        chk("t2_no_accept", acc_a.size(), 0);
        chk("t2_req_valid", imem_req_valid, 1);
        chk("t2_req_addr", imem_req_addr, 32'h8000_000C);
        chk("t2_no_inst", hs_c.size(), 0);

        // 3) IDU stalls in HOLD: outputs stable, no new request
        rdy_mode = 0; irdy_mode = 2;
        wait_valid();
        clr();
        repeat (4) cycle();
        chk("t3_no_req", acc_a.size(), 0);
        chk("t3_valid", inst_valid, 1);
        chk("t3_pc", inst_pc, 32'h8000_000C);

        // 4) redirect while waiting on a 3-cycle imem
        irdy_mode = 0; lat_min = 3; lat_max = 3; clr();
        cycle(); cycle();
        force_rv = 1; force_pc = 32'h8000_0100;
        repeat (11) cycle();
        chk("t4_old_addr", acc_a[0], 32'h8000_0010);
        chk("t4_new_addr", acc_a[1], 32'h8000_0100);
        chk("t4_first_pc", hs_pc[0], 32'h8000_000C);
        chk("t4_redir_pc", hs_pc[1], 32'h8000_0100);

        // 5) misaligned redirect, then a faulting fetch
        lat_min = 1; lat_max = 1; irdy_mode = 2;
        wait_valid();
        clr(); force_rv = 1; force_pc = 32'h8000_0102;
        cycle(); wait_valid();
        chk("t5_no_req", acc_a.size(), 0);
        chk("t5_mis_fault", inst_fault, 1);
        chk("t5_mis_inst", inst, 0);
        chk("t5_mis_pc", inst_pc, 32'h8000_0102);
        clr(); force_rv = 1; force_pc = 32'h8000_002C;
        cycle(); wait_valid();
        chk("t5_err_addr", acc_a[0], 32'h8000_002C);
        chk("t5_err_fault", inst_fault, 1);
        chk("t5_err_inst", inst, 0);
        chk("t5_err_pc", inst_pc, 32'h8000_002C);

        // 6) pc wrap, then reset during WAIT
        force_rv = 1; force_pc = 32'hFFFF_FFFC;
        cycle(); wait_valid();
        chk("t6_top_pc", inst_pc, 32'hFFFF_FFFC);
        irdy_mode = 0; lat_min = 5; lat_max = 5; clr();
        cycle(); cycle();
        chk("t6_wrap_addr", acc_a[0], 32'h0000_0000);
        cycle();
        rst_n = 0;
        #1;
        chk("t6_rst_req_valid", imem_req_valid, 0);
        chk("t6_rst_addr", imem_req_addr, RESET_PC);
        chk("t6_rst_inst_valid", inst_valid, 0);
        imem_rsp_valid = 0; redirect_valid = 0;
        repeat (2) @(negedge clk);
        model_reset(); lat_min = 1; lat_max = 1; spur_n = 2; clr();
        rst_n = 1;
        repeat (6) cycle();
        chk("t6_first_addr", acc_a[0], RESET_PC);
        chk("t6_first_pc", hs_pc[0], RESET_PC);

        // Random traffic against the stream model
        rdy_mode = 1; irdy_mode = 1; lat_min = 1; lat_max = 4; redir_rate = 10;
        n_hs = 0;
        repeat (3000) cycle();
        chk("rand_progress", 32'(n_hs > 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
